// File: rtl/check4_feature.sv
// Streaming 8-bit grayscale feature marker: a pixel that contrasts with all four
// causal neighbours (left, up-left, up, up-right) is replaced by MARK, 1-cycle latency.
module check4_feature #(
  parameter int         WIDTH     = 800,
  parameter int         HEIGHT    = 600,
  parameter logic [7:0] THRESHOLD = 8'd20,
  parameter logic [7:0] MARK      = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       valid,
  output logic [7:0] dout,
  output logic       validout
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;

  // hist_r[k] holds the pixel received k+1 valid beats ago
  logic [7:0] hist_r [0:WIDTH];

  logic [7:0] left_s;
  logic [7:0] upleft_s;
  logic [7:0] up_s;
  logic [7:0] upright_s;
  logic       border_s;
  logic       feature_s;
  logic [7:0] result_s;

  assign left_s    = hist_r[0];
  assign upright_s = hist_r[WIDTH-2];
  assign up_s      = hist_r[WIDTH-1];
  assign upleft_s  = hist_r[WIDTH];

  // Absolute difference at 9 bits so no wrap can occur, then strict compare
  function automatic logic exceeds(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return d > {1'b0, THRESHOLD};
  endfunction

  // Border detection and feature decision for the current beat
  always_comb begin
    border_s  = 1'b0;
    feature_s = 1'b0;
    result_s  = din;
    if ((row_r == {RW{1'b0}}) || (col_r == {CW{1'b0}}) || (col_r == CW'(WIDTH - 1))) begin
      border_s = 1'b1;
    end else begin
      border_s = 1'b0;
    end
    if (!border_s && exceeds(din, left_s) && exceeds(din, upleft_s) &&
        exceeds(din, up_s) && exceeds(din, upright_s)) begin
      feature_s = 1'b1;
      result_s  = MARK;
    end else begin
      feature_s = 1'b0;
      result_s  = din;
    end
  end

  // Delay line of valid beats; contents are left untouched by reset
  always_ff @(posedge clock) begin
    if (valid) begin
      hist_r[0] <= din;
      for (int i = 1; i <= WIDTH; i++) begin
        hist_r[i] <= hist_r[i-1];
      end
    end
  end

  // Raster position counters and registered output stage
  always_ff @(posedge clock) begin
    if (reset) begin
      col_r    <= {CW{1'b0}};
      row_r    <= {RW{1'b0}};
      dout     <= 8'h00;
      validout <= 1'b0;
    end else if (valid) begin
      dout     <= result_s;
      validout <= 1'b1;
      if (col_r == CW'(WIDTH - 1)) begin
        col_r <= {CW{1'b0}};
        if (row_r == RW'(HEIGHT - 1)) begin
          row_r <= {RW{1'b0}};
        end else begin
          row_r <= row_r + RW'(1);
        end
      end else begin
        col_r <= col_r + CW'(1);
      end
    end else begin
      validout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_check4_feature.sv
// Scoreboard bench for check4_feature on a 4x3 frame: directed scenarios plus
// randomized frames, checked against a beat-index reference model.
module tb_check4_feature;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int THR = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din   = 8'h00;
  logic       valid = 1'b0;
  logic [7:0] dout;
  logic       validout;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q   [$];
  logic [7:0] act_log [$];
  int         beats   [$];
  logic [7:0] fr      [N];

  bit         started = 1'b0;
  bit         exp_vo  = 1'b0;
  bit         rst_d   = 1'b0;
  logic [7:0] last_dout = 8'h00;

  check4_feature #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(8'd20), .MARK(8'hFF)) dut (
    .clock(clock), .reset(reset), .din(din), .valid(valid),
    .dout(dout), .validout(validout)
  );

  always #5 clock = ~clock;

  // Reference: position from beat count since reset; neighbours from past beats
  function automatic logic [7:0] model(input int n);
    int idx, r, c, p;
    int nb [4];
    bit feat;
    idx = n % N;
    r = idx / W;
    c = idx % W;
    p = beats[n];
    if (r == 0 || c == 0 || c == W - 1) return 8'(p);
    nb[0] = beats[n-1]; nb[1] = beats[n-W-1]; nb[2] = beats[n-W]; nb[3] = beats[n-W+1];
    feat = 1'b1;
    foreach (nb[k]) if (((p > nb[k]) ? p - nb[k] : nb[k] - p) <= THR) feat = 1'b0;
    return feat ? 8'hFF : 8'(p);
  endfunction

  always @(posedge clock) begin
    started <= 1'b1;
    exp_vo  <= valid && !reset;
    rst_d   <= reset;
  end

  // Monitor: validout timing, reset values, held dout, and scoreboard pops
  always @(negedge clock) begin
    if (started) begin
      tests++;
      if (validout !== exp_vo) begin
        fails++;
        $display("FAIL validout: got %b want %b at %0t", validout, exp_vo, $time);
      end
      if (rst_d) begin
        last_dout = 8'h00;
        tests++;
        if (dout !== 8'h00) begin
          fails++;
          $display("FAIL reset_dout: got %h want 00", dout);
        end
      end else if (validout) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got %h want no beat", dout);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (dout !== e) begin
            fails++;
            $display("FAIL dout_beat: got %h want %h at %0t", dout, e, $time);
          end
          last_dout = e;
        end
        act_log.push_back(dout);
      end else begin
        tests++;
        if (dout !== last_dout) begin
          fails++;
          $display("FAIL dout_hold: got %h want %h", dout, last_dout);
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] p);
    @(posedge clock); #1;
    din   = p;
    valid = 1'b1;
    beats.push_back(int'(p));
    exp_q.push_back(model(beats.size() - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      valid = 1'b0;
      din   = 8'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    valid = 1'b0;
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    beats.delete();
  endtask

  task automatic set_frame(input logic [7:0] bg);
    foreach (fr[i]) fr[i] = bg;
  endtask

  task automatic send_frame(input bit gapped);
    for (int i = 0; i < N; i++) begin
      if (gapped) idle(1);
      send_beat(fr[i]);
    end
    idle(3);
  endtask

  task automatic check_beat(input int idx, input logic [7:0] want, input string name);
    tests++;
    if (act_log.size() <= idx) begin
      fails++;
      $display("FAIL %s: got no beat %0d want %h", name, idx, want);
    end else if (act_log[idx] !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act_log[idx], want);
    end
  endtask

  task automatic check_count(input int want, input string name);
    tests++;
    if (act_log.size() != want) begin
      fails++;
      $display("FAIL %s: got %0d beats want %0d", name, act_log.size(), want);
    end
  endtask

  task automatic threshold_case(input logic [7:0] ctr, input logic [7:0] nbv,
                                input logic [7:0] upv, input logic [7:0] want,
                                input string name);
    set_frame(nbv);
    fr[1] = upv;
    fr[5] = ctr;
    act_log.delete();
    send_frame(1'b0);
    check_beat(5, want, name);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);

    // Flat frame
    act_log.delete();
    set_frame(8'h40);
    send_frame(1'b0);
    check_count(N, "flat_count");
    for (int i = 0; i < N; i++) check_beat(i, 8'h40, "flat_pix");

    // Spike at (1,1)
    act_log.delete();
    set_frame(8'h10); fr[5] = 8'hC8;
    send_frame(1'b0);
    for (int i = 0; i < N; i++) check_beat(i, (i == 5) ? 8'hFF : 8'h10, "spike");

    // Border spikes
    act_log.delete();
    set_frame(8'h10); fr[7] = 8'hC8;
    send_frame(1'b0);
    check_beat(7, 8'hC8, "border_r1c3");
    act_log.delete();
    set_frame(8'h10); fr[2] = 8'hC8; fr[4] = 8'hC8;
    send_frame(1'b0);
    check_beat(2, 8'hC8, "border_r0c2");
    check_beat(4, 8'hC8, "border_r1c0");

    // Threshold edges
    threshold_case(8'd48, 8'd28, 8'd28, 8'd48,  "thr_equal");
    threshold_case(8'd48, 8'd27, 8'd27, 8'hFF,  "thr_over");
    threshold_case(8'd0,  8'h80, 8'h80, 8'hFF,  "thr_below");
    threshold_case(8'hC8, 8'h10, 8'hC0, 8'hC8,  "thr_up_close");

    // Gapped spike frame
    act_log.delete();
    set_frame(8'h10); fr[5] = 8'hC8;
    send_frame(1'b1);
    for (int i = 0; i < N; i++) check_beat(i, (i == 5) ? 8'hFF : 8'h10, "gapped_spike");

    // Mid-frame reset then fresh spike frame
    for (int i = 0; i < 7; i++) send_beat(8'($urandom));
    do_reset(2);
    act_log.delete();
    send_frame(1'b0);
    check_beat(5, 8'hFF, "post_reset_spike");

    // Randomized frames with gaps and one mid-frame reset
    for (int f = 0; f < 8; f++) begin
      int cut;
      cut = (f == 4) ? int'($urandom_range(1, N - 1)) : N;
      for (int i = 0; i < cut; i++) begin
        int sel;
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        sel = int'($urandom_range(0, 2));
        send_beat(sel == 0 ? 8'h10 : (sel == 1 ? 8'hC8 : 8'($urandom)));
      end
      if (f == 4) do_reset(1);
    end
    idle(4);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
